// File: rtl/output_accumulate_buffer_pkg.sv
// Shared width helpers for the output accumulate buffer and its partners.
package mx_buffer_pkg;

  function automatic int acc_width(input int data_width, input int repeat_n);
    return data_width + $clog2(repeat_n);
  endfunction

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_accumulate_buffer_if.sv
// Input partial-sum stream and widened output stream of the accumulate buffer.
interface output_accumulate_buffer_if
  import mx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int REPEAT     = 4,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, REPEAT)
) ();
  logic signed [DATA_WIDTH-1:0] data_in [IN_NUM];
  logic                         data_in_valid;
  logic                         data_in_ready;
  logic signed [ACC_WIDTH-1:0]  data_out [IN_NUM];
  logic                         data_out_valid;
  logic                         data_out_ready;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/output_accumulate_buffer_acc_ram.sv
// Single-port accumulation RAM; registered read output holds while the port is idle.
module acc_ram
  import mx_buffer_pkg::*;
#(
  parameter int DATA  = 8,
  parameter int DEPTH = 512,
  parameter int ADDR_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA-1:0]   din,
  output logic [DATA-1:0]   dout
);
  logic [DATA-1:0] mem_reg [DEPTH];
  logic [DATA-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_reg[addr] <= din;
      end else begin
        dout_reg <= mem_reg[addr];
      end
    end
  end

  assign dout = dout_reg;
endmodule

// File: rtl/unpacked_register_slice.sv
// One-entry valid/ready register slice carrying an unpacked array of signed lanes.
module unpacked_register_slice #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_SIZE    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data [IN_SIZE],
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data [IN_SIZE],
  output logic                         out_valid,
  input  logic                         out_ready
);
  logic out_valid_reg;

  assign in_ready  = !out_valid_reg || out_ready;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else if (in_ready) begin
      out_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      out_data <= in_data;
    end
  end
endmodule

// File: rtl/output_accumulate_buffer.sv
// Accumulates REPEAT passes of BUFFER_SIZE beats per tile and emits the final sums on the last pass.
module output_accumulate_buffer
  import mx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_NUM      = 8,
  parameter int BUFFER_SIZE = 512,
  parameter int REPEAT      = 4,
  parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, REPEAT)
) (
  input  logic clk,
  input  logic rst,
  output_accumulate_buffer_if.slave bus
);
  localparam int BEAT_W = cnt_width(BUFFER_SIZE);
  localparam int PASS_W = cnt_width(REPEAT);
  localparam int RAM_W  = IN_NUM * ACC_WIDTH;

  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [PASS_W-1:0] pass_cnt_reg, pass_cnt_next;

  logic                        s1_valid_reg;
  logic                        s1_first_reg;
  logic                        s1_last_reg;
  logic [BEAT_W-1:0]           s1_addr_reg;
  logic signed [ACC_WIDTH-1:0] s1_in_reg [IN_NUM];

  logic signed [ACC_WIDTH-1:0] ram_rd [IN_NUM];
  logic signed [ACC_WIDTH-1:0] sum [IN_NUM];
  logic [RAM_W-1:0]            ram_din, ram_dout;
  logic [BEAT_W-1:0]           ram_addr;
  logic                        ram_en, ram_we;

  logic first_pass, last_pass, accept, s0_read, s1_write, s1_retire, slice_ready;

  assign first_pass = (pass_cnt_reg == '0);
  assign last_pass  = (pass_cnt_reg == PASS_W'(REPEAT - 1));
  assign s1_write   = s1_valid_reg && !s1_last_reg;
  assign s1_retire  = s1_valid_reg && (!s1_last_reg || slice_ready);

  // The single RAM port goes to the S1 write; a read-needing beat waits a cycle.
  assign bus.data_in_ready = (!s1_valid_reg || s1_retire) && !(s1_write && !first_pass);
  assign accept            = bus.data_in_valid && bus.data_in_ready;
  assign s0_read           = accept && !first_pass;

  assign ram_en   = s1_write || s0_read;
  assign ram_we   = s1_write;
  assign ram_addr = s1_write ? s1_addr_reg : beat_cnt_reg;

  generate
    for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_lane
      assign ram_rd[gi] = ram_dout[gi*ACC_WIDTH +: ACC_WIDTH];
      assign sum[gi]    = s1_first_reg ? s1_in_reg[gi] : ram_rd[gi] + s1_in_reg[gi];
      assign ram_din[gi*ACC_WIDTH +: ACC_WIDTH] = sum[gi];
    end
  endgenerate

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    pass_cnt_next = pass_cnt_reg;
    if (accept) begin
      if (beat_cnt_reg == BEAT_W'(BUFFER_SIZE - 1)) begin
        beat_cnt_next = '0;
        pass_cnt_next = last_pass ? '0 : pass_cnt_reg + 1'b1;
      end else begin
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      pass_cnt_reg <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
      pass_cnt_reg <= pass_cnt_next;
      if (accept) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_retire) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_first_reg <= first_pass;
      s1_last_reg  <= last_pass;
      s1_addr_reg  <= beat_cnt_reg;
      for (int i = 0; i < IN_NUM; i++) begin
        s1_in_reg[i] <= ACC_WIDTH'(bus.data_in[i]);
      end
    end
  end

  acc_ram #(
    .DATA  (RAM_W),
    .DEPTH (BUFFER_SIZE),
    .ADDR_W(BEAT_W)
  ) u_acc_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

  unpacked_register_slice #(
    .DATA_WIDTH(ACC_WIDTH),
    .IN_SIZE   (IN_NUM)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (sum),
    .in_valid (s1_valid_reg && s1_last_reg),
    .in_ready (slice_ready),
    .out_data (bus.data_out),
    .out_valid(bus.data_out_valid),
    .out_ready(bus.data_out_ready)
  );
endmodule
